// File: rtl/xbar_pkg.sv
// Shared definitions for the rotating-crossbar sequencer: geometry constants,
// sequencer state encoding and the phase-advance helper.
package xbar_pkg;

    localparam int LANES   = 16;
    localparam int PHASES  = 4;
    localparam int PHASE_W = $clog2(PHASES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } xbar_state_e;

    // Rotation schedule wraps PHASES-1 -> 0, so the step need not be a power of two.
    function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p);
        return (p == PHASE_W'(PHASES - 1)) ? '0 : p + PHASE_W'(1);
    endfunction

endpackage

// File: rtl/xbar_phase_cnt.sv
// Mod-PHASES rotation phase counter with synchronous clear (job start) and
// advance enable (beat fire).
module xbar_phase_cnt
    import xbar_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_en,
    output logic [PHASE_W-1:0] o_phase
);

    logic [PHASE_W-1:0] r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (i_clr) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= next_phase(r_phase);
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/crossbar_shift_ctrl.sv
// Sequencer for the 16-lane rotating crossbar: pulls lane vectors, drives start/clk_en/phase,
// and presents the crossbar output with valid/ready/last. Optional stall counter: CROSSBAR_SHIFT_CTRL_PERF_EN.
module crossbar_shift_ctrl
    import xbar_pkg::*;
#(
    parameter int BEATS_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [BEATS_W-1:0] cmd_beats,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               xb_start,
    output logic               xb_clk_en,
    output logic [PHASE_W-1:0] xb_phase,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done,
`ifdef CROSSBAR_SHIFT_CTRL_PERF_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic [1:0]         dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // cmd_ready and out_valid never depend on the partner's ready/valid.
    xbar_state_e        r_state;
    logic [BEATS_W-1:0] r_beats_total;
    logic [BEATS_W-1:0] r_issued;
    logic [BEATS_W-1:0] r_retired;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_fire;
    logic               w_out_hs;
    logic               w_last_out;
    logic               w_last_beat;
    logic [PHASE_W-1:0] w_phase;

    assign w_accept    = (r_state == IDLE) & cmd_valid;
    // The crossbar output register may be overwritten only if empty or draining this cycle.
    assign w_fire      = (r_state == RUN) & in_valid & (~r_out_valid | out_ready);
    assign w_out_hs    = r_out_valid & out_ready;
    assign w_last_out  = r_out_valid & (r_retired == r_beats_total - BEATS_W'(1));
    assign w_last_beat = (r_issued == r_beats_total - BEATS_W'(1));

    xbar_phase_cnt u_phase_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_accept),
        .i_en    (w_fire),
        .o_phase (w_phase)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_beats_total <= '0;
            r_issued      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_beats_total <= cmd_beats;
                        r_issued      <= '0;
                        r_state       <= (cmd_beats == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        r_issued <= r_issued + BEATS_W'(1);
                        if (w_last_beat) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_hs & w_last_out) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Mirrors the crossbar output register: loaded one cycle after fire, held under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_retired   <= '0;
        end else begin
            if (w_fire) begin
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_retired <= '0;
            end else if (w_out_hs) begin
                r_retired <= r_retired + BEATS_W'(1);
            end
        end
    end

`ifdef CROSSBAR_SHIFT_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if ((r_state == RUN || r_state == DRAIN) && r_out_valid && !out_ready
                     && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign cmd_ready = (r_state == IDLE);
    assign in_ready  = w_fire;
    assign xb_start  = w_fire;
    assign xb_clk_en = w_fire;
    assign xb_phase  = w_phase;
    assign out_valid = r_out_valid;
    assign out_last  = w_last_out;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_crossbar_shift_ctrl.sv
// Bench for crossbar_shift_ctrl: job-level counter model with an expected-phase queue,
// per-cycle compare on the falling edge, directed jobs plus randomized traffic.
`timescale 1ns/1ps
module tb_crossbar_shift_ctrl;
    import xbar_pkg::*;

    localparam int BW  = 8;
    localparam int NPH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [BW-1:0] cmd_beats = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          cmd_ready, in_ready, xb_start, xb_clk_en;
    logic          out_valid, out_last, busy, done;
    logic [PHASE_W-1:0] xb_phase;
    logic [1:0]    dbg_state;
`ifdef CROSSBAR_SHIFT_CTRL_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    crossbar_shift_ctrl #(.BEATS_W(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_beats (cmd_beats),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xb_start  (xb_start),
        .xb_clk_en (xb_clk_en),
        .xb_phase  (xb_phase),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
`ifdef CROSSBAR_SHIFT_CTRL_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A job is "active" from accept until its last vector is taken downstream; one vector may
    // be pending in the output register; phases of a job run 0,1,..,PHASES-1,0,...
    int  m_total, m_issued, m_retired, m_stall;
    bit  m_active, m_pend, m_done_pulse;
    logic [PHASE_W-1:0] exp_q[$];
    logic m_accept, m_fire, m_hs, m_last_hs;

    assign m_accept  = cmd_valid && !m_active && !m_done_pulse;
    assign m_fire    = m_active && (m_issued < m_total) && in_valid && (!m_pend || out_ready);
    assign m_hs      = m_pend && out_ready;
    assign m_last_hs = m_hs && (m_retired == m_total - 1);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_total      <= 0;
            m_issued     <= 0;
            m_retired    <= 0;
            m_stall      <= 0;
            m_active     <= 1'b0;
            m_pend       <= 1'b0;
            m_done_pulse <= 1'b0;
            exp_q.delete();
        end else begin
            m_done_pulse <= (m_accept && cmd_beats == '0) || m_last_hs;
            if (m_accept) begin
                m_total   <= int'(cmd_beats);
                m_issued  <= 0;
                m_retired <= 0;
                m_stall   <= 0;
                m_active  <= (cmd_beats != '0);
                for (int k = 0; k < int'(cmd_beats); k++) exp_q.push_back(PHASE_W'(k % NPH));
            end else begin
                if (m_fire) m_issued <= m_issued + 1;
                if (m_hs) m_retired <= m_retired + 1;
                if (m_last_hs) m_active <= 1'b0;
                if (m_active && m_pend && !out_ready && m_stall < 65535) m_stall <= m_stall + 1;
                if (m_fire && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (m_fire) m_pend <= 1'b1;
            else if (m_hs) m_pend <= 1'b0;
        end
    end

    // ---------------- compare / monitor ----------------
    int cyc = 0, fire_n = 0, hs_n = 0, ov_n = 0, done_n = 0, hs_cyc = 0, done_cyc = 0;
    int obs_ph[$];
    bit obs_last[$];

    always @(negedge clk) begin
        cyc++;
        chk("cmd_ready", cmd_ready, !m_active && !m_done_pulse);
        chk("busy", busy, m_active || m_done_pulse);
        chk("done", done, m_done_pulse);
        chk("in_ready", in_ready, m_fire);
        chk("xb_start", xb_start, m_fire);
        chk("xb_clk_en", xb_clk_en, m_fire);
        chk("out_valid", out_valid, m_pend);
        chk("out_last", out_last, m_pend && (m_retired == m_total - 1));
        if (m_fire && exp_q.size() > 0) chk("xb_phase", xb_phase, exp_q[0]);
`ifdef CROSSBAR_SHIFT_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        if (in_ready) begin
            fire_n++;
            obs_ph.push_back(int'(xb_phase));
        end
        if (out_valid && out_ready) begin
            hs_n++;
            obs_last.push_back(out_last);
            hs_cyc = cyc;
        end
        if (out_valid) ov_n++;
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int beats, input int pin, input int pout, input bit noise,
                           input int stall_at, output int acc_cyc);
        int d0, h0, n, stall_rem;
        bit stalled;
        d0 = done_n;
        h0 = hs_n;
        stall_rem = 0;
        stalled = 1'b0;
        cmd_valid = 1'b1;
        cmd_beats = BW'(beats);
        in_valid  = ($urandom_range(1, 100) <= pin);
        out_ready = ($urandom_range(1, 100) <= pout);
        step();
        acc_cyc = cyc;
        n = 0;
        while (done_n == d0 && n < 3000) begin
            cmd_valid = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            cmd_beats = BW'($urandom_range(0, 255));
            in_valid  = ($urandom_range(1, 100) <= pin);
            if (stall_at >= 0 && !stalled && (hs_n - h0) == stall_at) begin
                stalled = 1'b1;
                stall_rem = 3;
            end
            if (stall_rem > 0) begin
                out_ready = 1'b0;
                stall_rem--;
            end else begin
                out_ready = ($urandom_range(1, 100) <= pout);
            end
            step();
            n++;
        end
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("job_done_seen", done_n != d0, 1);
    endtask

    task automatic chk_phases(input string name, input int p0, input int n, input int first);
        chk({name, "_fires"}, obs_ph.size() - p0, n);
        for (int i = 0; i < n && p0 + i < obs_ph.size(); i++) chk({name, "_phase"}, obs_ph[p0 + i], (first + i) % NPH);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int p0, h0, l0, o0, acc, nlast;
        int t1_exp[4] = '{0, 1, 2, 3};

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_phase", xb_phase, 0);
        chk("rst_done", done, 0);

        // Job of 4 at full throughput
        p0 = obs_ph.size(); h0 = hs_n; l0 = obs_last.size();
        run_job(4, 100, 100, 1'b0, -1, acc);
        chk("t1_fires", obs_ph.size() - p0, 4);
        for (int i = 0; i < 4 && p0 + i < obs_ph.size(); i++) chk("t1_phase", obs_ph[p0 + i], t1_exp[i]);
        chk("t1_hs", hs_n - h0, 4);
        nlast = 0;
        for (int i = l0; i < obs_last.size(); i++) nlast += int'(obs_last[i]);
        chk("t1_last_count", nlast, 1);
        chk("t1_last_on_4th", (obs_last.size() == l0 + 4) ? obs_last[l0 + 3] : 1'b0, 1);
        chk("t1_done_lat", done_cyc - hs_cyc, 1);

        // Job of 6: phase wraps
        p0 = obs_ph.size(); h0 = hs_n;
        run_job(6, 100, 100, 1'b0, -1, acc);
        chk_phases("t2", p0, 6, 0);
        chk("t2_hs", hs_n - h0, 6);

        // Backpressure for 3 cycles after the 2nd output
        p0 = obs_ph.size(); h0 = hs_n;
        run_job(4, 100, 100, 1'b0, 2, acc);
        chk_phases("t3", p0, 4, 0);
        chk("t3_hs", hs_n - h0, 4);
`ifdef CROSSBAR_SHIFT_CTRL_PERF_EN
        chk("t6_stall_at_done", stall_cnt, 3);
`endif

        // Zero-beat job
        p0 = obs_ph.size(); o0 = ov_n;
        run_job(0, 100, 100, 1'b0, -1, acc);
        chk("t4_fires", obs_ph.size() - p0, 0);
        chk("t4_out_valid", ov_n - o0, 0);
        chk("t4_done_lat", done_cyc - acc, 1);
`ifdef CROSSBAR_SHIFT_CTRL_PERF_EN
        chk("t6_stall_cleared", stall_cnt, 0);
`endif

        // Reset during beat 2 of 4
        cmd_valid = 1'b1; cmd_beats = BW'(4); in_valid = 1'b1; out_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        #2 reset = 1'b0;
        #1;
        chk("t5_in_ready", in_ready, 0);
        chk("t5_xb_start", xb_start, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        step();
        p0 = obs_ph.size();
        run_job(2, 100, 100, 1'b0, -1, acc);
        chk_phases("t5", p0, 2, 0);

        // Randomized traffic, with commands offered while busy
        for (int j = 0; j < 30; j++) begin
            run_job($urandom_range(0, 12), $urandom_range(30, 100), $urandom_range(30, 100), 1'b1, -1, acc);
            repeat ($urandom_range(0, 2)) step();
        end
        p0 = obs_ph.size(); h0 = hs_n;
        run_job(255, 80, 80, 1'b1, -1, acc);
        chk("big_fires", obs_ph.size() - p0, 255);
        chk("big_hs", hs_n - h0, 255);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
